// File: rtl/jamma_pkg.sv
// Shared types and constants for the JAMMA joystick bus scheduler.
package jamma_pkg;

    typedef enum logic {
        SETTLE = 1'b0,
        SAMPLE = 1'b1
    } state_t;

    typedef enum logic {
        P1 = 1'b0,
        P2 = 1'b1
    } slot_t;

    localparam logic [7:0] JOY_IDLE = 8'hFF;

    // The local joystick only drives the six direction/button bits of player 1.
    function automatic logic [7:0] p1_raw(input logic [7:0] jjoy, input logic [5:0] joystick);
        return jjoy & {2'b11, joystick};
    endfunction

endpackage

// File: rtl/jamma_debounce.sv
// Whole-word debouncer for one player: the output follows a candidate word once
// it has been seen on DEBOUNCE_COUNT consecutive load strobes.
module jamma_debounce
    import jamma_pkg::*;
#(
    parameter int DEBOUNCE_COUNT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       LOAD,
    input  logic [7:0] RAW,
    output logic [7:0] OUT
);

    localparam logic [3:0] CNT_MAX = 4'(DEBOUNCE_COUNT);

    logic [7:0] cand_q, cand_d;
    logic [3:0] cnt_q, cnt_d;
    logic [7:0] out_q, out_d;

    always_comb begin
        cand_d = cand_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        if (LOAD) begin
            if (RAW != cand_q) begin
                cand_d = RAW;
                cnt_d  = 4'd1;
            end else if (cnt_q != CNT_MAX) begin
                cnt_d = cnt_q + 4'd1;
            end
            // Decide on the updated count so the output moves on the qualifying sample.
            if (cnt_d == CNT_MAX) begin
                out_d = cand_d;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            cand_q <= JOY_IDLE;
            cnt_q  <= CNT_MAX;
            out_q  <= JOY_IDLE;
        end else begin
            cand_q <= cand_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
        end
    end

    assign OUT = out_q;

endmodule

// File: rtl/jamma_input_scheduler.sv
// Time-multiplexes the JAMMA joystick bus between players 1 and 2 via JSELECT.
// Define JAMMA_DEBOUNCE_EN to debounce each player word before it reaches JOY1/JOY2.
module jamma_input_scheduler
    import jamma_pkg::*;
#(
    parameter int SETTLE_CYCLES  = 4,
    parameter int DEBOUNCE_COUNT = 3
) (
    input  logic       CLK,
    input  logic       RESET,
    input  logic       HOLD,
    input  logic [7:0] JJOY,
    input  logic [5:0] JOYSTICK,
    output logic       JSELECT,
    output logic [7:0] JOY1,
    output logic [7:0] JOY2,
    output logic       SCAN_DONE
);

    localparam int                CNT_W    = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(SETTLE_CYCLES - 1);

    if (SETTLE_CYCLES < 1 || SETTLE_CYCLES > 255) begin : g_bad_settle
        $error("SETTLE_CYCLES must be in 1..255");
    end
    if (DEBOUNCE_COUNT < 1 || DEBOUNCE_COUNT > 15) begin : g_bad_debounce
        $error("DEBOUNCE_COUNT must be in 1..15");
    end

    state_t           state_q, state_d;
    slot_t            slot_q, slot_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             scan_done_q, scan_done_d;
    logic [7:0]       raw;
    logic             load_p1, load_p2;

    // NOTE: every always_comb output gets a default first, so no path can infer a latch.
    always_comb begin
        state_d     = state_q;
        slot_d      = slot_q;
        cnt_d       = cnt_q;
        scan_done_d = scan_done_q;
        load_p1     = 1'b0;
        load_p2     = 1'b0;
        raw         = (slot_q == P1) ? p1_raw(JJOY, JOYSTICK) : JJOY;
        // HOLD leaves every register, including the SCAN_DONE pulse, exactly as it was.
        if (!HOLD) begin
            scan_done_d = 1'b0;
            unique case (state_q)
                SETTLE: begin
                    if (cnt_q == CNT_LAST) begin
                        state_d = SAMPLE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SAMPLE: begin
                    state_d     = SETTLE;
                    cnt_d       = '0;
                    slot_d      = (slot_q == P1) ? P2 : P1;
                    load_p1     = (slot_q == P1);
                    load_p2     = (slot_q == P2);
                    scan_done_d = (slot_q == P2);
                end
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q     <= SETTLE;
            slot_q      <= P1;
            cnt_q       <= '0;
            scan_done_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            slot_q      <= slot_d;
            cnt_q       <= cnt_d;
            scan_done_q <= scan_done_d;
        end
    end

    assign JSELECT   = (slot_q == P2);
    assign SCAN_DONE = scan_done_q;

`ifdef JAMMA_DEBOUNCE_EN
    jamma_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_debounce_p1 (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (load_p1),
        .RAW   (raw),
        .OUT   (JOY1)
    );

    jamma_debounce #(.DEBOUNCE_COUNT(DEBOUNCE_COUNT)) u_debounce_p2 (
        .CLK   (CLK),
        .RESET (RESET),
        .LOAD  (load_p2),
        .RAW   (raw),
        .OUT   (JOY2)
    );
`else
    logic [7:0] joy1_q, joy1_d;
    logic [7:0] joy2_q, joy2_d;

    always_comb begin
        joy1_d = load_p1 ? raw : joy1_q;
        joy2_d = load_p2 ? raw : joy2_q;
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            joy1_q <= JOY_IDLE;
            joy2_q <= JOY_IDLE;
        end else begin
            joy1_q <= joy1_d;
            joy2_q <= joy2_d;
        end
    end

    assign JOY1 = joy1_q;
    assign JOY2 = joy2_q;
`endif

endmodule

// File: tb/tb_jamma_input_scheduler.sv
// Directed bench for jamma_input_scheduler; per-scan expectations are queued and
// compared when SCAN_DONE fires. Works with or without JAMMA_DEBOUNCE_EN.
module tb_jamma_input_scheduler;

    typedef struct {
        string      tag;
        int         cyc;
        logic [7:0] joy1;
        logic [7:0] joy2;
    } scan_exp_t;

    logic       clk = 1'b0;
    logic       reset;
    logic       hold;
    logic [7:0] p1_word;
    logic [7:0] p2_word;
    logic [5:0] joystick;
    logic [7:0] jjoy;
    logic       jselect;
    logic [7:0] joy1;
    logic [7:0] joy2;
    logic       scan_done;

    int        checks   = 0;
    int        failures = 0;
    int        cyc      = 0;
    scan_exp_t sb[$];

    // The external multiplexer: the bus shows whichever player JSELECT picks.
    assign jjoy = jselect ? p2_word : p1_word;

    always #5 clk = ~clk;

    jamma_input_scheduler #(
        .SETTLE_CYCLES  (4),
        .DEBOUNCE_COUNT (3)
    ) dut (
        .CLK       (clk),
        .RESET     (reset),
        .HOLD      (hold),
        .JJOY      (jjoy),
        .JOYSTICK  (joystick),
        .JSELECT   (jselect),
        .JOY1      (joy1),
        .JOY2      (joy2),
        .SCAN_DONE (scan_done)
    );

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic goto(input int n);
        while (cyc < n) begin
            @(negedge clk);
            cyc++;
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        cyc   = 0;
    endtask

    task automatic expect_scan(input string tag, input int at, input logic [7:0] j1, input logic [7:0] j2);
        scan_exp_t e;
        e.tag  = tag;
        e.cyc  = at;
        e.joy1 = j1;
        e.joy2 = j2;
        sb.push_back(e);
    endtask

    task automatic wait_scan();
        scan_exp_t e;
        int        budget;
        e      = sb.pop_front();
        budget = 0;
        do begin
            @(negedge clk);
            cyc++;
            budget++;
        end while (scan_done !== 1'b1 && budget < 40);
        check({e.tag, "_seen"}, {7'd0, scan_done}, 8'h01);
        check({e.tag, "_cycle"}, 8'(cyc), 8'(e.cyc));
        check({e.tag, "_joy1"}, joy1, e.joy1);
        check({e.tag, "_joy2"}, joy2, e.joy2);
    endtask

    initial begin
        reset    = 1'b1;
        hold     = 1'b0;
        p1_word  = 8'hFF;
        p2_word  = 8'hFF;
        joystick = 6'h3F;

        // Idle bus: select timing and scan pulses.
        do_reset();
        check("rst_jsel", {7'd0, jselect}, 8'h00);
        check("rst_joy1", joy1, 8'hFF);
        check("rst_joy2", joy2, 8'hFF);
        check("rst_scan", {7'd0, scan_done}, 8'h00);
        goto(4);
        check("idle_jsel_c4", {7'd0, jselect}, 8'h00);
        goto(5);
        check("idle_jsel_c5", {7'd0, jselect}, 8'h01);
        check("idle_scan_c5", {7'd0, scan_done}, 8'h00);
        goto(9);
        check("idle_jsel_c9", {7'd0, jselect}, 8'h01);
        expect_scan("idle_scan1", 10, 8'hFF, 8'hFF);
        wait_scan();
        check("idle_jsel_c10", {7'd0, jselect}, 8'h00);
        goto(11);
        check("idle_scan_c11", {7'd0, scan_done}, 8'h00);
        goto(15);
        check("idle_jsel_c15", {7'd0, jselect}, 8'h01);
        expect_scan("idle_scan2", 20, 8'hFF, 8'hFF);
        wait_scan();

        // Distinct words per player.
        p1_word = 8'hFE;
        p2_word = 8'h7F;
        do_reset();
`ifdef JAMMA_DEBOUNCE_EN
        goto(24);
        check("data_joy1_c24", joy1, 8'hFF);
        goto(25);
        check("data_joy1_c25", joy1, 8'hFE);
        expect_scan("data_scan", 30, 8'hFE, 8'h7F);
`else
        goto(4);
        check("data_joy1_c4", joy1, 8'hFF);
        goto(5);
        check("data_joy1_c5", joy1, 8'hFE);
        check("data_joy2_c5", joy2, 8'hFF);
        expect_scan("data_scan", 10, 8'hFE, 8'h7F);
`endif
        wait_scan();

        // Local joystick merges into player 1 only.
        p1_word  = 8'hFF;
        p2_word  = 8'hFF;
        joystick = 6'h3B;
        do_reset();
`ifdef JAMMA_DEBOUNCE_EN
        expect_scan("local_scan", 30, 8'hFB, 8'hFF);
`else
        expect_scan("local_scan", 10, 8'hFB, 8'hFF);
`endif
        wait_scan();
        joystick = 6'h3F;

        // Single-slot glitch on the player 1 word.
        p1_word = 8'hF0;
        do_reset();
`ifdef JAMMA_DEBOUNCE_EN
        goto(24);
        check("glitch_joy1_c24", joy1, 8'hFF);
        goto(25);
        check("glitch_joy1_c25", joy1, 8'hF0);
        goto(30);
        p1_word = 8'h00;
        goto(35);
        p1_word = 8'hF0;
        check("glitch_joy1_c35", joy1, 8'hF0);
        expect_scan("glitch_scan", 40, 8'hF0, 8'hFF);
        wait_scan();
        for (int c = 45; c <= 70; c += 5) begin
            goto(c);
            check("glitch_joy1_hold", joy1, 8'hF0);
        end
`else
        goto(5);
        check("glitch_joy1_c5", joy1, 8'hF0);
        goto(30);
        p1_word = 8'h00;
        goto(35);
        p1_word = 8'hF0;
        check("glitch_joy1_c35", joy1, 8'h00);
        goto(45);
        check("glitch_joy1_c45", joy1, 8'hF0);
`endif

        // HOLD high for cycles 2..11 delays the player 1 sample to cycle 14.
        p1_word = 8'hFE;
        p2_word = 8'hFF;
        do_reset();
        goto(2);
        hold = 1'b1;
        for (int c = 2; c <= 11; c++) begin
            goto(c);
            check("hold_jsel", {7'd0, jselect}, 8'h00);
            check("hold_joy1", joy1, 8'hFF);
        end
        goto(12);
        hold = 1'b0;
        goto(14);
        check("hold_jsel_c14", {7'd0, jselect}, 8'h00);
        goto(15);
        check("hold_jsel_c15", {7'd0, jselect}, 8'h01);
`ifdef JAMMA_DEBOUNCE_EN
        check("hold_joy1_c15", joy1, 8'hFF);
        expect_scan("hold_scan", 20, 8'hFF, 8'hFF);
`else
        check("hold_joy1_c15", joy1, 8'hFE);
        expect_scan("hold_scan", 20, 8'hFE, 8'hFF);
`endif
        wait_scan();

        // RESET during the player 2 settle restarts from player 1.
        do_reset();
        goto(5);
`ifdef JAMMA_DEBOUNCE_EN
        check("midrst_joy1_c5", joy1, 8'hFF);
`else
        check("midrst_joy1_c5", joy1, 8'hFE);
`endif
        goto(7);
        reset = 1'b1;
        goto(8);
        reset = 1'b0;
        check("midrst_jsel", {7'd0, jselect}, 8'h00);
        check("midrst_joy1", joy1, 8'hFF);
        check("midrst_joy2", joy2, 8'hFF);
        cyc = 0;
        goto(4);
        check("midrst_jsel_c4", {7'd0, jselect}, 8'h00);
        goto(5);
        check("midrst_jsel_c5", {7'd0, jselect}, 8'h01);
`ifdef JAMMA_DEBOUNCE_EN
        expect_scan("midrst_scan", 30, 8'hFE, 8'hFF);
`else
        expect_scan("midrst_scan", 10, 8'hFE, 8'hFF);
`endif
        wait_scan();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/jamma_input_scheduler.md
# jamma_input_scheduler

Time-multiplexes the shared JAMMA joystick bus (JJOY) between player 1 and player 2. It drives the JSELECT line, waits for the external multiplexer to settle, and samples the bus into per-player registers. It can optionally debounce each player word. It sits between the board pins and the arcade core's I_JOYSTICK_A/B and I_PLAYER inputs, and replaces the free-running per-clock select toggle.

## Interface
- SETTLE_CYCLES, 4: cycles JSELECT is held stable before a sample; legal range 1..255.
- DEBOUNCE_COUNT, 3: consecutive identical samples per player required before the output updates; legal range 1..15. Used only when debounce is compiled in.
- CLK  in  1  pixel/system clock (PCLK domain)
- RESET  in  1  synchronous, active-high
- HOLD  in  1  freezes the scheduler while high
- JJOY  in  8  active-low JAMMA bus; bits [5:0] directions/buttons, bit 7 start
- JOYSTICK  in  6  active-low local joystick, merged into player 1 only
- JSELECT  out  1  0 = player 1 selected, 1 = player 2 selected
- JOY1  out  8  player 1 word, active-low
- JOY2  out  8  player 2 word, active-low
- SCAN_DONE  out  1  one-cycle pulse when a full P1+P2 scan completes

## Operation
- FSM states:
  - SETTLE: a counter increments every cycle. When it reaches SETTLE_CYCLES-1 the FSM goes to SAMPLE.
  - SAMPLE: lasts one cycle. It captures the raw word, toggles JSELECT, clears the counter and returns to SETTLE.
- Raw capture:
  - Player 1 slot (JSELECT=0): raw = JJOY & {2'b11, JOYSTICK}.
  - Player 2 slot (JSELECT=1): raw = JJOY.
- Without debounce, JOYx takes the raw value on every sample of its slot.
- Debounce is per player, on the whole 8-bit word:
  - If raw differs from the candidate: candidate <= raw, count <= 1.
  - Otherwise count increments, saturating at DEBOUNCE_COUNT.
  - When count == DEBOUNCE_COUNT, JOYx <= candidate.
- SCAN_DONE pulses in the cycle after the player 2 SAMPLE, aligned with the JOY2 update opportunity.
- HOLD=1 freezes the counter, state, JSELECT, captures and SCAN_DONE. No sample is taken in a held SAMPLE cycle. Scheduling resumes exactly where it stopped.
- Reset values:
  - JSELECT=0, JOY1=JOY2=8'hFF, SCAN_DONE=0.
  - State SETTLE, counter 0.
  - Candidates 8'hFF, counts saturated at DEBOUNCE_COUNT.
- RESET mid-scan discards any partial slot and restarts at player 1 SETTLE.
- Simultaneous RESET and HOLD: RESET wins.

## Timing
- Cycle 0 is the first cycle with RESET low. With SETTLE_CYCLES=4:
  - Cycles 0..3: SETTLE with JSELECT=0.
  - Cycle 4: SAMPLE player 1.
  - Cycle 5: JOY1 updated (no debounce); JSELECT=1.
  - Cycles 5..8: SETTLE for player 2.
  - Cycle 9: SAMPLE player 2.
  - Cycle 10: JOY2 updated, SCAN_DONE=1, JSELECT=0.
- Slot period is SETTLE_CYCLES+1; scan period is 2*(SETTLE_CYCLES+1).
- With debounce, a steady input change reaches JOYx DEBOUNCE_COUNT slot-samples after it first appears at a sample point.
- All outputs are registered; there are no combinational input-to-output paths.

## Configuration
- JAMMA_DEBOUNCE_EN defined: instantiate the debounce logic described above.
- JAMMA_DEBOUNCE_EN undefined: JOYx loads raw directly; candidate and count registers are not built; DEBOUNCE_COUNT is ignored.

## Structure
- Shared package jamma_pkg holds:
  - the state enum (SETTLE, SAMPLE);
  - JOY_IDLE = 8'hFF;
  - a slot type (P1=0, P2=1).
- One sub-module, jamma_debounce, instantiated twice (one per player). It has ports CLK, RESET, load strobe, raw[7:0] and out[7:0], and is compiled only under JAMMA_DEBOUNCE_EN.
- The counter width is sized from SETTLE_CYCLES.

## Test plan
- Reset release, JJOY=8'hFF, JOYSTICK=6'h3F: JSELECT toggles at cycles 5, 10, 15, ...; JOY1=JOY2=8'hFF; SCAN_DONE high at cycles 10, 20, ...
- No debounce: JJOY=8'hFE while JSELECT=0 and 8'h7F while JSELECT=1 → JOY1=8'hFE from cycle 5, JOY2=8'h7F from cycle 10.
- JOYSTICK=6'h3B, JJOY=8'hFF → JOY1=8'hFB and JOY2 stays 8'hFF; the local joystick never leaks into P2.
- Debounce with DEBOUNCE_COUNT=3: P1 bus set to 8'hF0 from cycle 0 → JOY1 stays 8'hFF until 8'hF0 appears after the third P1 sample (cycle 25). A single-sample glitch to 8'h00 never reaches JOY1.
- HOLD high for cycles 2..11 → JSELECT stays 0 and no JOY1 update occurs; the P1 SAMPLE happens at cycle 14 and JSELECT rises at cycle 15.
- RESET pulsed at cycle 7 (mid P2 settle) → JSELECT=0 the next cycle, JOY1/JOY2=8'hFF, and the sequence restarts from cycle 0 timing.
